hazard_ctrl: RTL and testbench

- Parametrised stall/flush controller for the out-of-order pipeline: fetch (IF), rename (RN), dispatch (DISP) and issue (ISSUE).
- Each cycle it compares the resource demand of the current rename and dispatch groups with the free counts of the freelist, ROB and issue queue.
- Contains a flush/recovery FSM that sequences pipeline flushes on mispredict and waits for rename-map recovery before resuming.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/hazard_perf_counter.sv | 20 ++
 rtl/hazard_ctrl.sv | 172 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard (stall/flush) controller.
package hazard_pkg;

  localparam int unsigned PERF_CNT_W = 32;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    RECOVER = 2'd2
  } hazard_state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    IQ   = 2'd1,
    ROB  = 2'd2,
    FL   = 2'd3
  } stall_cause_e;

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating event counter with enable; holds at all-ones.
module hazard_perf_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count enabled cycles, stopping at the maximum value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the IF/RN/DISP/ISSUE pipeline front.
// Resource stalls are resolved combinationally in RUN; a small FSM sequences
// flush and rename-map recovery. Optional performance counters are built
// when HAZARD_PERF_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned DISPATCH_WIDTH = 2,
  parameter int unsigned FREELIST_DEPTH = 32,
  parameter int unsigned ROB_DEPTH      = 16,
  parameter int unsigned IQ_DEPTH       = 8,
  parameter int unsigned MIN_RECOVER    = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [$clog2(FREELIST_DEPTH+1)-1:0]  freelist_free,
  input  logic [$clog2(ROB_DEPTH+1)-1:0]       rob_free,
  input  logic [$clog2(IQ_DEPTH+1)-1:0]        iq_free,
  input  logic [$clog2(DISPATCH_WIDTH+1)-1:0]  rn_dest_cnt,
  input  logic [$clog2(DISPATCH_WIDTH+1)-1:0]  disp_cnt,
  input  logic                                 flush_req,
  input  logic                                 recover_done,
  output logic                                 stall_if,
  output logic                                 stall_rn,
  output logic                                 stall_disp,
  output logic                                 stall_issue,
  output logic                                 flush_if,
  output logic                                 flush_rn,
  output logic                                 flush_disp,
  output logic                                 flush_issue,
  output logic                                 busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0]                perf_iq_stall,
  output logic [PERF_CNT_W-1:0]                perf_rob_stall,
  output logic [PERF_CNT_W-1:0]                perf_fl_stall,
  output logic [PERF_CNT_W-1:0]                perf_flush_cycles
`endif
);

  localparam int unsigned FL_W  = $clog2(FREELIST_DEPTH+1);
  localparam int unsigned ROB_W = $clog2(ROB_DEPTH+1);
  localparam int unsigned IQ_W  = $clog2(IQ_DEPTH+1);
  localparam int unsigned CNT_W = $clog2(DISPATCH_WIDTH+1);
  localparam int unsigned CMP_A = (FL_W > ROB_W) ? FL_W : ROB_W;
  localparam int unsigned CMP_B = (CMP_A > IQ_W) ? CMP_A : IQ_W;
  localparam int unsigned CMP_W = (CMP_B > CNT_W) ? CMP_B : CNT_W;
  localparam int unsigned REC_W = $clog2(MIN_RECOVER+1);
  localparam logic [REC_W-1:0] REC_LOAD = REC_W'(MIN_RECOVER-1);

  hazard_state_e    state;
  hazard_state_e    state_nx;
  logic [REC_W-1:0] rec_cnt;
  logic             flush_q;
  logic             busy_q;
  logic             iq_short_c;
  logic             rob_short_c;
  logic             fl_short_c;
  stall_cause_e     cause_c;

  // Resource shortfalls and the prioritised stall reason for this cycle.
  always_comb begin
    iq_short_c  = CMP_W'(disp_cnt) > CMP_W'(iq_free);
    rob_short_c = CMP_W'(disp_cnt) > CMP_W'(rob_free);
    fl_short_c  = CMP_W'(rn_dest_cnt) > CMP_W'(freelist_free);
    cause_c     = NONE;
    if (iq_short_c) begin
      cause_c = IQ;
    end else if (rob_short_c) begin
      cause_c = ROB;
    end else if (fl_short_c) begin
      cause_c = FL;
    end
  end

  // Next state: a flush request always restarts the flush sequence.
  always_comb begin
    state_nx = state;
    case (state)
      RUN: begin
        if (flush_req) state_nx = FLUSH;
      end
      FLUSH: begin
        state_nx = flush_req ? FLUSH : RECOVER;
      end
      RECOVER: begin
        if (flush_req) begin
          state_nx = FLUSH;
        end else if ((rec_cnt == '0) && recover_done) begin
          state_nx = RUN;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  // State, minimum-recovery counter and registered flush/busy flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      rec_cnt <= '0;
      flush_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      flush_q <= (state_nx == FLUSH);
      busy_q  <= (state_nx != RUN);
      if (state == FLUSH) begin
        rec_cnt <= REC_LOAD;
      end else if ((state == RECOVER) && (rec_cnt != '0)) begin
        rec_cnt <= rec_cnt - REC_W'(1);
      end
    end
  end

  // Stall outputs: resource-driven in RUN, FSM-driven otherwise. Issue is
  // only held during the flush cycle so that IQ/ROB can always drain.
  always_comb begin
    stall_if    = 1'b0;
    stall_rn    = 1'b0;
    stall_disp  = 1'b0;
    stall_issue = 1'b0;
    if (busy_q) begin
      stall_if    = flush_q;
      stall_rn    = 1'b1;
      stall_disp  = 1'b1;
      stall_issue = flush_q;
    end else begin
      stall_if    = (cause_c != NONE);
      stall_rn    = (cause_c != NONE);
      stall_disp  = (cause_c == IQ) || (cause_c == ROB);
    end
  end

  assign flush_if    = flush_q;
  assign flush_rn    = flush_q;
  assign flush_disp  = flush_q;
  assign flush_issue = flush_q;
  assign busy        = busy_q;

`ifdef HAZARD_PERF_EN
  // Per-cause RUN stall counters plus busy-cycle counter.
  hazard_perf_counter #(.W(PERF_CNT_W)) u_perf_iq (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!busy_q && (cause_c == IQ)),
    .count (perf_iq_stall)
  );

  hazard_perf_counter #(.W(PERF_CNT_W)) u_perf_rob (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!busy_q && (cause_c == ROB)),
    .count (perf_rob_stall)
  );

  hazard_perf_counter #(.W(PERF_CNT_W)) u_perf_fl (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!busy_q && (cause_c == FL)),
    .count (perf_fl_stall)
  );

  hazard_perf_counter #(.W(PERF_CNT_W)) u_perf_flush (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (busy_q),
    .count (perf_flush_cycles)
  );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomised self-checking bench for hazard_ctrl against a behavioural model.
module tb_hazard_ctrl;

  localparam int unsigned DW    = 2;
  localparam int unsigned FLD   = 32;
  localparam int unsigned ROBD  = 16;
  localparam int unsigned IQD   = 8;
  localparam int unsigned MINR  = 2;
  localparam int unsigned FL_W  = $clog2(FLD+1);
  localparam int unsigned ROB_W = $clog2(ROBD+1);
  localparam int unsigned IQ_W  = $clog2(IQD+1);
  localparam int unsigned CNT_W = $clog2(DW+1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [FL_W-1:0]  freelist_free;
  logic [ROB_W-1:0] rob_free;
  logic [IQ_W-1:0]  iq_free;
  logic [CNT_W-1:0] rn_dest_cnt;
  logic [CNT_W-1:0] disp_cnt;
  logic             flush_req;
  logic             recover_done;
  logic stall_if, stall_rn, stall_disp, stall_issue;
  logic flush_if, flush_rn, flush_disp, flush_issue;
  logic busy;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_iq_stall, perf_rob_stall, perf_fl_stall, perf_flush_cycles;
`endif

  hazard_ctrl #(
    .DISPATCH_WIDTH (DW),
    .FREELIST_DEPTH (FLD),
    .ROB_DEPTH      (ROBD),
    .IQ_DEPTH       (IQD),
    .MIN_RECOVER    (MINR)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .freelist_free (freelist_free),
    .rob_free      (rob_free),
    .iq_free       (iq_free),
    .rn_dest_cnt   (rn_dest_cnt),
    .disp_cnt      (disp_cnt),
    .flush_req     (flush_req),
    .recover_done  (recover_done),
    .stall_if      (stall_if),
    .stall_rn      (stall_rn),
    .stall_disp    (stall_disp),
    .stall_issue   (stall_issue),
    .flush_if      (flush_if),
    .flush_rn      (flush_rn),
    .flush_disp    (flush_disp),
    .flush_issue   (flush_issue),
    .busy          (busy)
`ifdef HAZARD_PERF_EN
    ,
    .perf_iq_stall     (perf_iq_stall),
    .perf_rob_stall    (perf_rob_stall),
    .perf_fl_stall     (perf_fl_stall),
    .perf_flush_cycles (perf_flush_cycles)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Model: whether the pipeline is busy, whether this is the flush cycle,
  // and how many recovery cycles have elapsed.
  bit          m_busy;
  bit          m_flushing;
  int unsigned m_rec;
  longint unsigned m_iq, m_rob, m_fl, m_busy_cyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [8:0] dut_out();
    return {stall_if, stall_rn, stall_disp, stall_issue,
            flush_if, flush_rn, flush_disp, flush_issue, busy};
  endfunction

  // Expected {stall if/rn/disp/issue, flush x4, busy} from the stage rules.
  function automatic logic [8:0] model_out(input int unsigned ff, rf, qf, rd, dc);
    bit disp_blk, fl_blk;
    if (m_flushing) return 9'h1FF;
    if (m_busy) return 9'b0110_0000_1;
    disp_blk = (dc > qf) || (dc > rf);
    fl_blk   = (rd > ff);
    return {disp_blk || fl_blk, disp_blk || fl_blk, disp_blk, 1'b0, 4'b0000, 1'b0};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_flushing = 0; m_rec = 0;
    m_iq = 0; m_rob = 0; m_fl = 0; m_busy_cyc = 0;
  endtask

  task automatic model_clock(input int unsigned ff, rf, qf, rd, dc, input bit fr, rdn);
    if (m_busy) m_busy_cyc++;
    else if (dc > qf) m_iq++;
    else if (dc > rf) m_rob++;
    else if (rd > ff) m_fl++;
    if (fr) begin
      m_busy = 1; m_flushing = 1; m_rec = 0;
    end else if (m_flushing) begin
      m_flushing = 0; m_rec = 0;
    end else if (m_busy) begin
      if ((m_rec + 1 >= MINR) && rdn) m_busy = 0;
      else m_rec++;
    end
  endtask

  // Apply one cycle of inputs, check outputs mid-cycle, then clock the model.
  task automatic step(input string tag, input int unsigned ff, rf, qf, rd, dc,
                      input bit fr, rdn);
    @(negedge clk);
    freelist_free = FL_W'(ff);
    rob_free      = ROB_W'(rf);
    iq_free       = IQ_W'(qf);
    rn_dest_cnt   = CNT_W'(rd);
    disp_cnt      = CNT_W'(dc);
    flush_req     = fr;
    recover_done  = rdn;
    #1;
    check(tag, 64'(dut_out()), 64'(model_out(ff, rf, qf, rd, dc)));
    @(posedge clk);
    model_clock(ff, rf, qf, rd, dc, fr, rdn);
  endtask

  initial begin
    rst_n = 1'b0;
    freelist_free = '0; rob_free = '0; iq_free = '0;
    rn_dest_cnt = '0; disp_cnt = '0; flush_req = 1'b0; recover_done = 1'b0;
    model_reset();
    #2;
    check("reset_out", 64'(dut_out()), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Resource stall boundaries.
    step("iq_short",     32, 16, 1, 0, 2, 0, 0);
    step("iq_equal",     32, 16, 2, 0, 2, 0, 0);
    step("rob_short",    32, 1, 8, 0, 2, 0, 0);
    step("fl_short",     1, 16, 8, 2, 0, 0, 0);
    step("fl_zero_zero", 0, 16, 8, 0, 0, 0, 0);
    step("disp0_free0",  0, 0, 0, 0, 0, 0, 0);
    step("fl_equal",     2, 16, 8, 2, 2, 0, 0);

    // Flush then minimum recovery with recover_done held high.
    step("flush_req",    32, 16, 8, 0, 0, 1, 1);
    step("flush_cyc",    32, 16, 8, 0, 0, 0, 1);
    step("recover1",     32, 16, 8, 2, 2, 0, 1);
    step("recover2",     32, 16, 8, 0, 0, 0, 1);
    step("back_run",     32, 16, 1, 0, 2, 0, 1);

    // Flush wins over recover_done; flush re-requested inside FLUSH.
    step("f2_req",       32, 16, 8, 0, 0, 1, 0);
    step("f2_reflush",   32, 16, 8, 0, 0, 1, 0);
    step("f2_flush",     32, 16, 8, 0, 0, 0, 1);
    step("f2_rec1",      32, 16, 8, 0, 0, 0, 1);
    step("f2_rec_fr",    32, 16, 8, 0, 0, 1, 1);
    step("f2_flush_b",   32, 16, 8, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step("rec_hold", 0, 0, 0, 2, 2, 0, 0);
    step("rec_release",  32, 16, 8, 0, 0, 0, 1);
    step("run_again",    32, 16, 8, 0, 0, 0, 0);

    // Asynchronous reset in the middle of recovery.
    step("ar_req",       32, 16, 8, 0, 0, 1, 0);
    step("ar_flush",     32, 16, 8, 0, 0, 0, 0);
    step("ar_rec",       32, 16, 8, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 64'({flush_if, flush_rn, flush_disp, flush_issue, busy}), 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst",     32, 16, 8, 0, 0, 0, 1);

    // Five ROB-limited cycles with IQ not short.
    for (int i = 0; i < 5; i++) step("rob_run", 32, 1, 8, 0, 2, 0, 0);
`ifdef HAZARD_PERF_EN
    #1;
    check("perf_rob5", 64'(perf_rob_stall), 64'd5);
    check("perf_iq0",  64'(perf_iq_stall), 64'd0);
`endif

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step("rand",
           $urandom_range(0, FLD), $urandom_range(0, ROBD), $urandom_range(0, IQD),
           $urandom_range(0, DW), $urandom_range(0, DW),
           ($urandom_range(0, 11) == 0), ($urandom_range(0, 2) != 0));
    end

`ifdef HAZARD_PERF_EN
    #1;
    check("perf_iq",    64'(perf_iq_stall), 64'(m_iq));
    check("perf_rob",   64'(perf_rob_stall), 64'(m_rob));
    check("perf_fl",    64'(perf_fl_stall), 64'(m_fl));
    check("perf_flush", 64'(perf_flush_cycles), 64'(m_busy_cyc));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
